fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (a power of two, at least 2).
REQ-002 SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC_IF  input  XLEN  PC of the instruction currently presented by fetch.
REQ-006 SHALL have port INSTRUCTION_IF  input  XLEN  instruction word at PC_IF.
REQ-007 SHALL have port PCSrc  input  1  taken-branch redirect, which flushes the queue.
REQ-008 SHALL have port ID_ready  input  1  decode accepts the head entry this cycle.
REQ-009 SHALL have port PC_write  output  1  fetch may advance; the presented instruction is accepted.
REQ-010 SHALL have port PC_ID  output  XLEN  PC of the head entry.
REQ-011 SHALL have port INSTRUCTION_ID  output  XLEN  instruction of the head entry.
REQ-012 SHALL have port ID_valid  output  1  head entry is valid.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH entries, each holding {PC, instruction}, with read and write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-014 SHALL drive PC_write = (count < DEPTH), decoded from registered state only, with no combinational path from ID_ready.
REQ-015 SHALL push on a rising edge when PC_write=1 and PCSrc=0, writing {PC_IF, INSTRUCTION_IF} at the write pointer.
REQ-016 SHALL pop on a rising edge when ID_valid=1, ID_ready=1 and PCSrc=0.
REQ-017 SHALL drive ID_valid = (count != 0).
REQ-018 SHALL present the head entry combinationally from storage, so that the latency from push to visible at head is 1 cycle when the queue is empty.
REQ-019 SHALL drive INSTRUCTION_ID = 32'h00000013 (NOP) and PC_ID = 0 when the queue is empty.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop while advancing both pointers.
REQ-021 SHALL block pushes when full, including when a pop occurs in the same cycle (no bypass); PC_write rises on the cycle after the pop.
REQ-022 SHALL give PCSrc=1 priority over push and pop: pointers and count clear to 0 at the edge, and the instruction at PC_IF is discarded as wrong-path.
REQ-023 SHALL wrap pointers modulo DEPTH without a gap or lost entry.
REQ-024 SHALL never overflow or underflow; count stays in the range 0..DEPTH.

Reset
REQ-025 SHALL, while reset=0, clear pointers and count asynchronously, giving ID_valid=0, PC_write=1, PC_ID=0 and INSTRUCTION_ID=NOP.
REQ-026 SHALL not reset the storage array; outputs are defined by count alone.
REQ-027 SHALL discard all entries on reset asserted mid-operation; the first push after release lands in entry 0.

Structure
REQ-028 SHALL take the XLEN and NOP constants from the shared package riscv_pkg, which is also used by the decode stage.
REQ-029 SHALL be a single module with inline storage; no sub-module is needed.

Verification
REQ-030 SHALL verify reset then a single push: PC_IF=0x0, INSTRUCTION_IF=0x00500093, ID_ready=0 -> after 1 edge, ID_valid=1, PC_ID=0x0, INSTRUCTION_ID=0x00500093, PC_write=1.
REQ-031 SHALL verify fill: 4 pushes with PCs 0x0, 0x4, 0x8, 0xC and ID_ready=0 -> PC_write=0 after the 4th edge; a 5th instruction is not stored; head stays PC 0x0.
REQ-032 SHALL verify full with a pop: ID_ready=1 for 1 cycle -> head becomes 0x4, count 3, PC_write=1 on the next cycle only, per REQ-021.
REQ-033 SHALL verify flush: queue holds 3 entries, PCSrc=1 with PC_IF=0x20 -> next cycle ID_valid=0 and INSTRUCTION_ID=NOP; the 0x20 instruction is not stored.
REQ-034 SHALL verify wrap-around: 10 cycles of continuous push and pop with PCs 0x0..0x24 -> decode receives all 10 in order, none missing or duplicated.
REQ-035 SHALL verify reset mid-stream: reset=0 asynchronously with 2 entries held -> ID_valid=0 immediately without waiting for a clock edge; after release, the first push is seen at head next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants used by fetch and decode stages.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- canonical NOP presented when no instruction is held
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage : riscv_pkg

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instruction}
// with flush on taken-branch redirect and no full-queue bypass.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_IF,
  input  logic [XLEN-1:0] INSTRUCTION_IF,
  input  logic            PCSrc,
  input  logic            ID_ready,
  output logic            PC_write,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] INSTRUCTION_ID,
  output logic            ID_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic push, pop;

  // Handshake flags come from registered occupancy only
  always_comb begin
    PC_write = (count_q < CW'(DEPTH));
    ID_valid = (count_q != '0);
    push     = PC_write & ~PCSrc;
    pop      = ID_valid & ID_ready & ~PCSrc;
  end

  // Head entry straight from storage; NOP/zero when empty
  always_comb begin
    PC_ID          = '0;
    INSTRUCTION_ID = XLEN'(riscv_pkg::NOP);
    if (ID_valid) begin
      PC_ID          = pc_mem_q[rd_ptr_q];
      INSTRUCTION_ID = instr_mem_q[rd_ptr_q];
    end
  end

  // Next-state pointers and count; redirect overrides push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (PCSrc) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, intentionally not reset (outputs gated by count)
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= PC_IF;
      instr_mem_q[wr_ptr_q] <= INSTRUCTION_IF;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus enqueues expected entries,
// a monitor pops and compares whenever decode accepts the head.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] PC_IF, INSTRUCTION_IF;
  logic        PCSrc, ID_ready;
  logic        PC_write, ID_valid;
  logic [31:0] PC_ID, INSTRUCTION_ID;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_pops;

  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_IF          (PC_IF),
    .INSTRUCTION_IF (INSTRUCTION_IF),
    .PCSrc          (PCSrc),
    .ID_ready       (ID_ready),
    .PC_write       (PC_write),
    .PC_ID          (PC_ID),
    .INSTRUCTION_ID (INSTRUCTION_ID),
    .ID_valid       (ID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; exp_push marks a cycle where the entry must be stored
  task automatic step(input logic [31:0] pc, input logic src, input logic rdy,
                      input logic exp_push);
    PC_IF          = pc;
    INSTRUCTION_IF = ins_of(pc);
    PCSrc          = src;
    ID_ready       = rdy;
    if (src) sb.delete();
    if (exp_push) sb.push_back({pc, ins_of(pc)});
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens at the next edge when these hold at the negedge
  initial begin
    forever begin
      @(negedge clk);
      if (reset && ID_valid && ID_ready && !PCSrc) begin
        n_pops++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mon_unexpected_pop: got pc %h expected none", PC_ID);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("mon_pc", PC_ID, e[63:32]);
          chk("mon_instr", INSTRUCTION_ID, e[31:0]);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; n_pops = 0;
    reset = 1'b0; PCSrc = 1'b0; ID_ready = 1'b0;
    PC_IF = '0; INSTRUCTION_IF = '0;
    #3;
    chk("rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_pcw",   {31'd0, PC_write}, 32'd1);
    chk("rst_pc",    PC_ID, 32'd0);
    chk("rst_instr", INSTRUCTION_ID, NOP);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // single push
    PC_IF = 32'h0; INSTRUCTION_IF = 32'h0050_0093; PCSrc = 1'b0; ID_ready = 1'b0;
    sb.push_back({32'h0, 32'h0050_0093});
    @(posedge clk); #1;
    chk("push1_valid", {31'd0, ID_valid}, 32'd1);
    chk("push1_pc",    PC_ID, 32'h0);
    chk("push1_instr", INSTRUCTION_ID, 32'h0050_0093);
    chk("push1_pcw",   {31'd0, PC_write}, 32'd1);

    // fill to 4
    step(32'h4, 1'b0, 1'b0, 1'b1);
    step(32'h8, 1'b0, 1'b0, 1'b1);
    chk("fill3_pcw", {31'd0, PC_write}, 32'd1);
    step(32'hC, 1'b0, 1'b0, 1'b1);
    chk("full_pcw",  {31'd0, PC_write}, 32'd0);
    chk("full_head", PC_ID, 32'h0);
    step(32'h10, 1'b0, 1'b0, 1'b0);
    chk("full5_pcw",  {31'd0, PC_write}, 32'd0);
    chk("full5_head", PC_ID, 32'h0);

    // pop while full: push blocked, PC_write rises after
    step(32'h10, 1'b0, 1'b1, 1'b0);
    chk("fpop_head",  PC_ID, 32'h4);
    chk("fpop_pcw",   {31'd0, PC_write}, 32'd1);
    chk("fpop_valid", {31'd0, ID_valid}, 32'd1);
    step(32'h10, 1'b0, 1'b0, 1'b1);
    chk("refill_pcw", {31'd0, PC_write}, 32'd0);

    // drop to 3 entries, then flush
    step(32'h14, 1'b0, 1'b1, 1'b0);
    chk("three_pcw",  {31'd0, PC_write}, 32'd1);
    chk("three_head", PC_ID, 32'h8);
    step(32'h20, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, ID_valid}, 32'd0);
    chk("flush_instr", INSTRUCTION_ID, NOP);
    chk("flush_pc",    PC_ID, 32'h0);
    chk("flush_pcw",   {31'd0, PC_write}, 32'd1);

    // continuous push/pop across pointer wrap
    n_pops = 0;
    for (int i = 0; i < 10; i++) step(32'(i * 4), 1'b0, 1'b1, 1'b1);
    chk("wrap_head", PC_ID, 32'h24);
    step(32'h28, 1'b0, 1'b1, 1'b1);
    chk("wrap_pops", n_pops, 32'd10);
    chk("wrap_head2", PC_ID, 32'h28);
    step(32'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_flush_valid", {31'd0, ID_valid}, 32'd0);

    // asynchronous reset mid-stream
    step(32'h30, 1'b0, 1'b0, 1'b1);
    step(32'h34, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_valid", {31'd0, ID_valid}, 32'd1);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("arst_valid", {31'd0, ID_valid}, 32'd0);
    chk("arst_pcw",   {31'd0, PC_write}, 32'd1);
    chk("arst_instr", INSTRUCTION_ID, NOP);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(32'h40, 1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", {31'd0, ID_valid}, 32'd1);
    chk("post_rst_pc",    PC_ID, 32'h40);
    chk("post_rst_instr", INSTRUCTION_ID, ins_of(32'h40));
    step(32'h44, 1'b0, 1'b1, 1'b1);
    chk("post_rst_head2", PC_ID, 32'h44);
    step(32'h0, 1'b1, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_queue
